// File: rtl/fb_writer.sv
// Write-side master for the 128x32 framebuffer RAM: packs a 2-bit-per-channel
// pixel byte stream four-to-a-word, or fills the whole frame with one colour.
module fb_writer #(
    parameter int WORDS     = 75,
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 sof,
    input  logic                 fill_req,
    input  logic [5:0]           fill_color,
    output logic                 we,
    output logic [ADDR_BITS-1:0] address,
    output logic [31:0]          data,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [1:0] {
        ACCEPT,
        WRITE,
        FILL
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(WORDS - 1);
    localparam logic [ADDR_BITS-1:0] ONE  = ADDR_BITS'(1);

    state_t               state, state_nx;
    logic [1:0]           k, k_nx, idx;
    logic [ADDR_BITS-1:0] wptr, wptr_nx, address_nx;
    logic [31:0]          pack, pack_nx, data_nx;
    logic                 we_nx, frame_done_nx;
    logic                 accept;

    // NOTE: in_ready is combinational, so it is gated by reset explicitly to stay low while reset is held.
    assign in_ready = (state == ACCEPT) && !fill_req && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ACCEPT);

    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_nx      = state;
        k_nx          = k;
        idx           = k;
        wptr_nx       = wptr;
        pack_nx       = pack;
        we_nx         = 1'b0;
        address_nx    = address;
        data_nx       = data;
        frame_done_nx = 1'b0;

        case (state)
            ACCEPT: begin
                if (fill_req) begin
                    state_nx      = FILL;
                    we_nx         = 1'b1;
                    address_nx    = '0;
                    data_nx       = {4{2'b00, fill_color}};
                    frame_done_nx = (WORDS == 1);
                    k_nx          = '0;
                    wptr_nx       = '0;
                    pack_nx       = '0;
                end else begin
                    if (sof) begin
                        idx     = '0;
                        k_nx    = '0;
                        wptr_nx = '0;
                        pack_nx = '0;
                    end
                    if (accept) begin
                        // Byte 0 is the leftmost pixel, so byte idx lands at [31-8*idx -: 8].
                        pack_nx[{~idx, 3'b000} +: 8] = in_data;
                        k_nx = idx + 2'd1;
                        if (idx == 2'd3) begin
                            state_nx      = WRITE;
                            we_nx         = 1'b1;
                            address_nx    = wptr_nx;
                            data_nx       = pack_nx;
                            frame_done_nx = (wptr_nx == LAST);
                            wptr_nx       = (wptr_nx == LAST) ? '0 : wptr_nx + ONE;
                        end
                    end
                end
            end

            WRITE: begin
                state_nx = ACCEPT;
            end

            FILL: begin
                if (address == LAST) begin
                    state_nx = ACCEPT;
                end else begin
                    we_nx         = 1'b1;
                    address_nx    = address + ONE;
                    frame_done_nx = (address_nx == LAST);
                end
            end

            default: begin
                state_nx = ACCEPT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ACCEPT;
            k          <= '0;
            wptr       <= '0;
            pack       <= '0;
            we         <= 1'b0;
            address    <= '0;
            data       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            k          <= k_nx;
            wptr       <= wptr_nx;
            pack       <= pack_nx;
            we         <= we_nx;
            address    <= address_nx;
            data       <= data_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule
